// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one sram-like memory port between inst_cache and data_cache.
// Define ARB_RR_EN for round-robin tie-breaking; default build gives data fixed priority over inst.
//
// state   | meaning
// IDLE    | no transaction; registered pick of the next owner from pending ben
// GRANT_I | inst owns the port (pre- or post-accept)
// GRANT_D | data owns the port (pre- or post-accept)
module mem_port_arbiter #(
    parameter int LINE_BEATS  = 8,
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [3:0]  inst_ben,
    input  logic        inst_uncached,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_beat_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic [3:0]  data_ben,
    input  logic        data_wr,
    input  logic        data_uncached,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_beat_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  ram_ben,
    output logic        ram_wr,
    output logic        ram_uncached,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_addr_ok,
    input  logic        ram_beat_ok,
    input  logic        ram_data_ok,
    input  logic [31:0] ram_rdata,
    output logic        arb_busy,
    output logic        arb_owner,
    output logic        arb_err
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t             state;
    logic               accepted;
    logic [31:0]        acc_addr;
    logic               acc_wr;
    logic               acc_unc;
    logic [7:0]         beat_cnt;
    logic [CNT_W-1:0]   wd_cnt;

    logic [3:0]         own_ben;
    logic               own_wr;
    logic               own_unc;
    logic [31:0]        own_addr;
    logic               inst_pend;
    logic               data_pend;
    logic               prefer_data;
    logic               grant_d;
    logic [7:0]         beats_total;
    logic [7:0]         beats_exp;
    logic               fwd_addr_ok;
    logic               fwd_beat_ok;
    logic               fwd_data_ok;

`ifdef ARB_RR_EN
    // Last served requester; starts as inst so the first tie goes to data.
    logic last_data;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            last_data <= 1'b0;
        else if (state == IDLE && (inst_pend || data_pend))
            last_data <= grant_d;
    end

    assign prefer_data = !last_data;
`else
    assign prefer_data = 1'b1;
`endif

    assign inst_pend = (inst_ben != 4'd0);
    assign data_pend = (data_ben != 4'd0);
    assign grant_d   = data_pend && (!inst_pend || prefer_data);

    always_comb begin
        own_ben  = arb_owner ? data_ben : inst_ben;
        own_wr   = arb_owner & data_wr;
        own_unc  = arb_owner ? data_uncached : inst_uncached;
        own_addr = arb_owner ? data_addr : inst_addr;

        ram_ben      = 4'd0;
        ram_wr       = 1'b0;
        ram_uncached = 1'b0;
        ram_addr     = 32'd0;
        ram_wdata    = 32'd0;
        if (arb_busy) begin
            ram_wdata = arb_owner ? data_wdata : 32'd0;
            if (accepted) begin
                ram_wr       = acc_wr;
                ram_uncached = acc_unc;
                ram_addr     = acc_addr;
            end else begin
                ram_ben      = own_ben;
                ram_wr       = own_wr;
                ram_uncached = own_unc;
                ram_addr     = own_addr;
            end
        end
    end

    assign fwd_addr_ok = arb_busy && !accepted && ram_addr_ok;
    assign fwd_beat_ok = arb_busy && ram_beat_ok;
    assign fwd_data_ok = arb_busy && ram_data_ok;

    assign inst_addr_ok = fwd_addr_ok && !arb_owner;
    assign inst_beat_ok = fwd_beat_ok && !arb_owner;
    assign inst_data_ok = fwd_data_ok && !arb_owner;
    assign data_addr_ok = fwd_addr_ok && arb_owner;
    assign data_beat_ok = fwd_beat_ok && arb_owner;
    assign data_data_ok = fwd_data_ok && arb_owner;
    assign inst_rdata   = ram_rdata;
    assign data_rdata   = ram_rdata;

    // The beat that arrives together with ram_data_ok is part of the count.
    assign beats_total = beat_cnt + {7'd0, ram_beat_ok};
    assign beats_exp   = ram_uncached ? 8'd1 : 8'(LINE_BEATS);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            arb_busy  <= 1'b0;
            arb_owner <= 1'b0;
            arb_err   <= 1'b0;
            accepted  <= 1'b0;
            acc_addr  <= 32'd0;
            acc_wr    <= 1'b0;
            acc_unc   <= 1'b0;
            beat_cnt  <= 8'd0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    accepted <= 1'b0;
                    beat_cnt <= 8'd0;
                    wd_cnt   <= '0;
                    if (ram_addr_ok || ram_beat_ok || ram_data_ok)
                        arb_err <= 1'b1;
                    if (grant_d) begin
                        state     <= GRANT_D;
                        arb_busy  <= 1'b1;
                        arb_owner <= 1'b1;
                    end else if (inst_pend) begin
                        state     <= GRANT_I;
                        arb_busy  <= 1'b1;
                        arb_owner <= 1'b0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (ram_beat_ok)
                        beat_cnt <= beat_cnt + 8'd1;

                    // Watchdog saturates at the limit; the FSM keeps waiting.
                    if (ram_addr_ok || ram_beat_ok)
                        wd_cnt <= '0;
                    else if (wd_cnt != CNT_W'(TIMEOUT_CYC)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1))
                            arb_err <= 1'b1;
                    end

                    if (!accepted && ram_addr_ok) begin
                        accepted <= 1'b1;
                        acc_addr <= own_addr;
                        acc_wr   <= own_wr;
                        acc_unc  <= own_unc;
                    end

                    if (ram_data_ok) begin
                        if (beats_total != beats_exp)
                            arb_err <= 1'b1;
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                        accepted <= 1'b0;
                    end else if (!accepted && !ram_addr_ok && own_ben == 4'd0) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, handshakes, beat-count and watchdog errors, reset.
// Expected grant order depends on ARB_RR_EN, matching the design build.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        cpu_clk_50M;
    logic        cpu_rst_n;
    logic [3:0]  inst_ben;
    logic        inst_uncached;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_beat_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  data_ben;
    logic        data_wr, data_uncached;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_beat_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  ram_ben;
    logic        ram_wr, ram_uncached;
    logic [31:0] ram_addr, ram_wdata;
    logic        ram_addr_ok, ram_beat_ok, ram_data_ok;
    logic [31:0] ram_rdata;
    logic        arb_busy, arb_owner, arb_err;

    int n_chk = 0;
    int n_err = 0;

`ifdef ARB_RR_EN
    localparam logic [2:0] ORDER = 3'b101;
`else
    localparam logic [2:0] ORDER = 3'b111;
`endif

    mem_port_arbiter dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .inst_ben     (inst_ben),
        .inst_uncached(inst_uncached),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_beat_ok (inst_beat_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_ben     (data_ben),
        .data_wr      (data_wr),
        .data_uncached(data_uncached),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_beat_ok (data_beat_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_ben      (ram_ben),
        .ram_wr       (ram_wr),
        .ram_uncached (ram_uncached),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_addr_ok  (ram_addr_ok),
        .ram_beat_ok  (ram_beat_ok),
        .ram_data_ok  (ram_data_ok),
        .ram_rdata    (ram_rdata),
        .arb_busy     (arb_busy),
        .arb_owner    (arb_owner),
        .arb_err      (arb_err)
    );

    initial cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic clear_ram();
        ram_addr_ok = 1'b0;
        ram_beat_ok = 1'b0;
        ram_data_ok = 1'b0;
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
    endtask

    // Accept the owner's request, then one beat with data_ok; leaves the FSM in its dead IDLE cycle.
    task automatic finish_single();
        ram_addr_ok = 1'b1;
        tick();
        clear_ram();
        ram_beat_ok = 1'b1;
        ram_data_ok = 1'b1;
        tick();
        clear_ram();
    endtask

    initial begin
        cpu_rst_n     = 1'b0;
        inst_ben      = 4'd0;
        inst_uncached = 1'b0;
        inst_addr     = 32'd0;
        data_ben      = 4'd0;
        data_wr       = 1'b0;
        data_uncached = 1'b0;
        data_addr     = 32'd0;
        data_wdata    = 32'd0;
        ram_rdata     = 32'd0;
        clear_ram();
        #1;
        chk("rst_busy", {31'd0, arb_busy}, 32'd0);
        chk("rst_err", {31'd0, arb_err}, 32'd0);
        chk("rst_ben", {28'd0, ram_ben}, 32'd0);
        tick();
        tick();
        cpu_rst_n = 1'b1;
        tick();

        // Cached inst read, 8 beats
        inst_ben  = 4'hF;
        inst_addr = 32'h0000_1000;
        tick();
        chk("t1_busy", {31'd0, arb_busy}, 32'd1);
        chk("t1_owner", {31'd0, arb_owner}, 32'd0);
        chk("t1_ram_ben", {28'd0, ram_ben}, 32'hF);
        chk("t1_ram_addr", ram_addr, 32'h0000_1000);
        ram_addr_ok = 1'b1;
        #1;
        chk("t1_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
        chk("t1_data_aok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        clear_ram();
        inst_ben  = 4'd0;
        inst_addr = 32'hFFFF_FFFF;
        #1;
        chk("t1_ben_post", {28'd0, ram_ben}, 32'd0);
        chk("t1_addr_held", ram_addr, 32'h0000_1000);
        for (int i = 0; i < 8; i++) begin
            ram_beat_ok = 1'b1;
            ram_data_ok = (i == 7);
            ram_rdata   = 32'h100 + i;
            #1;
            chk("t1_inst_bok", {31'd0, inst_beat_ok}, 32'd1);
            chk("t1_rdata", inst_rdata, 32'h100 + i);
            chk("t1_data_bok", {31'd0, data_beat_ok}, 32'd0);
            if (i == 7) begin
                chk("t1_inst_dok", {31'd0, inst_data_ok}, 32'd1);
                chk("t1_data_dok", {31'd0, data_data_ok}, 32'd0);
            end
            tick();
        end
        clear_ram();
        chk("t1_idle", {31'd0, arb_busy}, 32'd0);
        chk("t1_err", {31'd0, arb_err}, 32'd0);

        // Simultaneous requests: data first, inst after one dead cycle
        inst_ben      = 4'hF;
        inst_uncached = 1'b1;
        inst_addr     = 32'h0000_2000;
        data_ben      = 4'hF;
        data_uncached = 1'b1;
        data_addr     = 32'h0000_3000;
        tick();
        chk("t2_owner_d", {31'd0, arb_owner}, 32'd1);
        chk("t2_addr_d", ram_addr, 32'h0000_3000);
        ram_addr_ok = 1'b1;
        tick();
        clear_ram();
        data_ben    = 4'd0;
        ram_beat_ok = 1'b1;
        ram_data_ok = 1'b1;
        #1;
        chk("t2_data_dok", {31'd0, data_data_ok}, 32'd1);
        chk("t2_inst_dok", {31'd0, inst_data_ok}, 32'd0);
        tick();
        clear_ram();
        chk("t2_dead", {31'd0, arb_busy}, 32'd0);
        tick();
        chk("t2_busy_i", {31'd0, arb_busy}, 32'd1);
        chk("t2_owner_i", {31'd0, arb_owner}, 32'd0);
        finish_single();
        inst_ben = 4'd0;
        chk("t2_err", {31'd0, arb_err}, 32'd0);

        // Both held for three transactions
        inst_ben = 4'hF;
        data_ben = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t3_owner%0d", k), {31'd0, arb_owner}, {31'd0, ORDER[k]});
            finish_single();
        end
        inst_ben = 4'd0;
        data_ben = 4'd0;
        tick();

        // Uncached partial write
        data_ben      = 4'b0011;
        data_wr       = 1'b1;
        data_uncached = 1'b1;
        data_addr     = 32'h2000_0004;
        data_wdata    = 32'hA5A5_0001;
        tick();
        chk("t4_ram_wr", {31'd0, ram_wr}, 32'd1);
        chk("t4_ram_ben", {28'd0, ram_ben}, 32'h3);
        chk("t4_ram_unc", {31'd0, ram_uncached}, 32'd1);
        chk("t4_wdata0", ram_wdata, 32'hA5A5_0001);
        ram_addr_ok = 1'b1;
        tick();
        clear_ram();
        data_ben    = 4'd0;
        data_wr     = 1'b0;
        data_wdata  = 32'hDEAD_BEEF;
        ram_beat_ok = 1'b1;
        ram_data_ok = 1'b1;
        #1;
        chk("t4_wdata1", ram_wdata, 32'hDEAD_BEEF);
        chk("t4_wr_held", {31'd0, ram_wr}, 32'd1);
        chk("t4_bok", {31'd0, data_beat_ok}, 32'd1);
        chk("t4_dok", {31'd0, data_data_ok}, 32'd1);
        tick();
        clear_ram();
        chk("t4_idle", {31'd0, arb_busy}, 32'd0);
        chk("t4_err", {31'd0, arb_err}, 32'd0);

        // Abort before acceptance
        inst_ben      = 4'hF;
        inst_uncached = 1'b0;
        tick();
        chk("ab_busy", {31'd0, arb_busy}, 32'd1);
        inst_ben = 4'd0;
        tick();
        chk("ab_idle", {31'd0, arb_busy}, 32'd0);
        chk("ab_err", {31'd0, arb_err}, 32'd0);

        // Cached read with only 7 beats
        inst_ben  = 4'hF;
        inst_addr = 32'h0000_4000;
        tick();
        ram_addr_ok = 1'b1;
        tick();
        clear_ram();
        inst_ben = 4'd0;
        for (int i = 0; i < 7; i++) begin
            ram_beat_ok = 1'b1;
            ram_data_ok = (i == 6);
            tick();
        end
        clear_ram();
        chk("t5_err", {31'd0, arb_err}, 32'd1);
        chk("t5_idle", {31'd0, arb_busy}, 32'd0);
        do_reset();
        chk("t5_err_rst", {31'd0, arb_err}, 32'd0);

        // Stray beat in IDLE
        ram_beat_ok = 1'b1;
        #1;
        chk("sp_fwd", {31'd0, inst_beat_ok}, 32'd0);
        tick();
        clear_ram();
        chk("sp_err", {31'd0, arb_err}, 32'd1);
        chk("sp_idle", {31'd0, arb_busy}, 32'd0);
        do_reset();

        // Watchdog after acceptance, then reset mid-wait
        inst_ben  = 4'hF;
        inst_addr = 32'h0000_5000;
        tick();
        ram_addr_ok = 1'b1;
        tick();
        clear_ram();
        inst_ben = 4'd0;
        repeat (1022) tick();
        chk("wd_err_pre", {31'd0, arb_err}, 32'd0);
        tick();
        chk("wd_err", {31'd0, arb_err}, 32'd1);
        chk("wd_busy", {31'd0, arb_busy}, 32'd1);
        repeat (5) tick();
        chk("wd_stay", {31'd0, arb_busy}, 32'd1);
        cpu_rst_n = 1'b0;
        #1;
        chk("wr_busy", {31'd0, arb_busy}, 32'd0);
        chk("wr_err", {31'd0, arb_err}, 32'd0);
        chk("wr_owner", {31'd0, arb_owner}, 32'd0);
        chk("wr_ben", {28'd0, ram_ben}, 32'd0);
        chk("wr_uncwr", {30'd0, ram_wr, ram_uncached}, 32'd0);
        chk("wr_oks", {26'd0, inst_addr_ok, inst_beat_ok, inst_data_ok,
                       data_addr_ok, data_beat_ok, data_data_ok}, 32'd0);
        tick();
        cpu_rst_n = 1'b1;
        tick();
        chk("wr_idle", {31'd0, arb_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
